hub_fifo_arbiter: RTL and testbench

- Traffic manager between one hub's parent link (upstream) and its DOWNSTREAM_FIFO_COUNT child links.
- Child-to-parent direction: merges all child FIFOs onto the single upstream channel with round-robin arbitration and a registered output stage.
- Parent-to-child direction: routes each parent message to one child by FPGA id, or to every child when the id is broadcast.
- Aggregates the children's message-flying and odd-cluster status into upstream flags for the stage controller.

---
 rtl/hub_fifo_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_hub_fifo_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub_fifo_arbiter.sv
// hub_fifo_arbiter: traffic manager between a hub's parent link and its child links.
//
// Child -> parent: round-robin merge of all child FIFOs into one registered
// upstream output stage (1-cycle latency, full throughput).
// Parent -> child: combinational routing by destination id (top FPGAID_WIDTH
// bits of the message); all-ones broadcasts to every child exactly once.
// Status: child flying/odd-cluster flags are OR-reduced into upstream flags.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   downstream_fifo_in_*            N child -> hub message streams (data/valid/ready)
//   upstream_fifo_out_*             merged hub -> parent stream
//   upstream_fifo_in_*              parent -> hub stream
//   downstream_fifo_out_*           hub -> N child streams (data replicated per slice)
//   downstream_has_message_flying   per-child in-flight status
//   downstream_has_odd_clusters     per-child odd-cluster status
//   upstream_has_message_flying     aggregated in-flight status
//   upstream_has_odd_clusters       aggregated odd-cluster status
//   route_error                     sticky flag: unicast to a nonexistent child
module hub_fifo_arbiter #(
    parameter int unsigned HUB_FIFO_WIDTH        = 40,
    parameter int unsigned DOWNSTREAM_FIFO_COUNT = 4,
    parameter int unsigned FPGAID_WIDTH          = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH-1:0]   downstream_fifo_in_data,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]                  downstream_fifo_in_valid,
    output logic [DOWNSTREAM_FIFO_COUNT-1:0]                  downstream_fifo_in_ready,
    output logic [HUB_FIFO_WIDTH-1:0]                         upstream_fifo_out_data,
    output logic                                              upstream_fifo_out_valid,
    input  logic                                              upstream_fifo_out_ready,
    input  logic [HUB_FIFO_WIDTH-1:0]                         upstream_fifo_in_data,
    input  logic                                              upstream_fifo_in_valid,
    output logic                                              upstream_fifo_in_ready,
    output logic [DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH-1:0]   downstream_fifo_out_data,
    output logic [DOWNSTREAM_FIFO_COUNT-1:0]                  downstream_fifo_out_valid,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]                  downstream_fifo_out_ready,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]                  downstream_has_message_flying,
    input  logic [DOWNSTREAM_FIFO_COUNT-1:0]                  downstream_has_odd_clusters,
    output logic                                              upstream_has_message_flying,
    output logic                                              upstream_has_odd_clusters,
    output logic                                              route_error
);

    localparam int unsigned W     = HUB_FIFO_WIDTH;
    localparam int unsigned N     = DOWNSTREAM_FIFO_COUNT;
    localparam int unsigned IDW   = FPGAID_WIDTH;
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    // Merge path state
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [PTR_W-1:0] rr_ptr_q;

    // Route path state
    logic [N-1:0]     bcast_done_q;
    logic [N-1:0]     bcast_done_d;
    logic             route_error_q;

    logic             load;
    logic             any_valid;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] rr_next;
    logic [W-1:0]     sel_data;

    logic [IDW-1:0]   dest;
    logic             is_bcast;
    logic             is_unicast;
    logic [N-1:0]     done_next;
    logic             err_set;

    // ------------------------------------------------------------------
    // Merge path
    // ------------------------------------------------------------------
    assign load = !out_valid_q || upstream_fifo_out_ready;

    // First valid child at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 0; k < int'(N); k++) begin
            idx = (int'(rr_ptr_q) + k) % int'(N);
            if (!any_valid && downstream_fifo_in_valid[PTR_W'(idx)]) begin
                any_valid = 1'b1;
                grant     = PTR_W'(idx);
            end
        end
    end

    assign rr_next = (grant == PTR_W'(N - 1)) ? '0 : grant + PTR_W'(1);

    always_comb begin
        sel_data                 = '0;
        downstream_fifo_in_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant == PTR_W'(i)) begin
                sel_data = downstream_fifo_in_data[i*W +: W];
            end
            downstream_fifo_in_ready[i] = !reset && load && any_valid &&
                                          (grant == PTR_W'(i));
        end
    end

    assign upstream_fifo_out_valid = out_valid_q;
    assign upstream_fifo_out_data  = out_data_q;

    // ------------------------------------------------------------------
    // Route path
    // ------------------------------------------------------------------
    assign dest       = upstream_fifo_in_data[W-1 -: IDW];
    assign is_bcast   = (dest == '1);
    assign is_unicast = (32'(dest) < N);

    assign downstream_fifo_out_data = {N{upstream_fifo_in_data}};

    always_comb begin
        downstream_fifo_out_valid = '0;
        upstream_fifo_in_ready    = 1'b0;
        done_next                 = bcast_done_q;
        bcast_done_d              = bcast_done_q;
        err_set                   = 1'b0;
        if (!reset) begin
            if (is_bcast) begin
                // Children already served for this message are masked off so each
                // gets exactly one copy; the parent holds the message until all are done.
                downstream_fifo_out_valid = {N{upstream_fifo_in_valid}} & ~bcast_done_q;
                done_next = bcast_done_q | (downstream_fifo_out_valid & downstream_fifo_out_ready);
                upstream_fifo_in_ready = &done_next;
                bcast_done_d = upstream_fifo_in_ready ? '0 : done_next;
            end else if (is_unicast) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (dest == IDW'(i)) begin
                        downstream_fifo_out_valid[i] = upstream_fifo_in_valid;
                        upstream_fifo_in_ready       = downstream_fifo_out_ready[i];
                    end
                end
            end else begin
                // Unroutable unicast: swallow it and flag the error.
                upstream_fifo_in_ready = 1'b1;
                err_set                = upstream_fifo_in_valid;
            end
        end
    end

    assign route_error = route_error_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            rr_ptr_q      <= '0;
            bcast_done_q  <= '0;
            route_error_q <= 1'b0;
        end else begin
            if (load) begin
                if (any_valid) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= sel_data;
                    rr_ptr_q    <= rr_next;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
            bcast_done_q <= bcast_done_d;
            if (err_set) begin
                route_error_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status aggregation
    // ------------------------------------------------------------------
    assign upstream_has_message_flying = (|downstream_has_message_flying) | out_valid_q |
                                         (|downstream_fifo_in_valid) | upstream_fifo_in_valid;
    assign upstream_has_odd_clusters   = |downstream_has_odd_clusters;

endmodule

// File: tb/tb_hub_fifo_arbiter.sv
module tb_hub_fifo_arbiter;

    localparam int W = 40;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N*W-1:0]   downstream_fifo_in_data;
    logic [N-1:0]     downstream_fifo_in_valid;
    logic [N-1:0]     downstream_fifo_in_ready;
    logic [W-1:0]     upstream_fifo_out_data;
    logic             upstream_fifo_out_valid;
    logic             upstream_fifo_out_ready;
    logic [W-1:0]     upstream_fifo_in_data;
    logic             upstream_fifo_in_valid;
    logic             upstream_fifo_in_ready;
    logic [N*W-1:0]   downstream_fifo_out_data;
    logic [N-1:0]     downstream_fifo_out_valid;
    logic [N-1:0]     downstream_fifo_out_ready;
    logic [N-1:0]     downstream_has_message_flying;
    logic [N-1:0]     downstream_has_odd_clusters;
    logic             upstream_has_message_flying;
    logic             upstream_has_odd_clusters;
    logic             route_error;

    logic [W-1:0]     child_data [N];

    hub_fifo_arbiter #(
        .HUB_FIFO_WIDTH        (W),
        .DOWNSTREAM_FIFO_COUNT (N),
        .FPGAID_WIDTH          (4)
    ) dut (
        .clk                           (clk),
        .reset                         (reset),
        .downstream_fifo_in_data       (downstream_fifo_in_data),
        .downstream_fifo_in_valid      (downstream_fifo_in_valid),
        .downstream_fifo_in_ready      (downstream_fifo_in_ready),
        .upstream_fifo_out_data        (upstream_fifo_out_data),
        .upstream_fifo_out_valid       (upstream_fifo_out_valid),
        .upstream_fifo_out_ready       (upstream_fifo_out_ready),
        .upstream_fifo_in_data         (upstream_fifo_in_data),
        .upstream_fifo_in_valid        (upstream_fifo_in_valid),
        .upstream_fifo_in_ready        (upstream_fifo_in_ready),
        .downstream_fifo_out_data      (downstream_fifo_out_data),
        .downstream_fifo_out_valid     (downstream_fifo_out_valid),
        .downstream_fifo_out_ready     (downstream_fifo_out_ready),
        .downstream_has_message_flying (downstream_has_message_flying),
        .downstream_has_odd_clusters   (downstream_has_odd_clusters),
        .upstream_has_message_flying   (upstream_has_message_flying),
        .upstream_has_odd_clusters     (upstream_has_odd_clusters),
        .route_error                   (route_error)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) downstream_fifo_in_data[i*W +: W] = child_data[i];
    end

    int errors = 0;
    int checks = 0;

    logic [W-1:0]   exp_up [$];
    logic [W+1:0]   exp_dn [$];   // {child index, message}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push_dn(input int child, input logic [W-1:0] msg);
        logic [W+1:0] e;
        logic [31:0]  c;
        c = child;
        e = {c[1:0], msg};
        exp_dn.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every handshake the DUT presents.
    always @(negedge clk) begin : monitor
        logic [W-1:0] eu;
        logic [W+1:0] ed;
        logic [W+1:0] got;
        logic [31:0]  ci;
        if (!reset) begin
            if (upstream_fifo_out_valid && upstream_fifo_out_ready) begin
                checks++;
                if (exp_up.size() == 0) begin
                    errors++;
                    $display("FAIL up_beat: got %0h required no beat", upstream_fifo_out_data);
                end else begin
                    eu = exp_up.pop_front();
                    if (upstream_fifo_out_data !== eu) begin
                        errors++;
                        $display("FAIL up_beat: got %0h required %0h",
                                 upstream_fifo_out_data, eu);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (downstream_fifo_out_valid[i] && downstream_fifo_out_ready[i]) begin
                    ci  = i;
                    got = {ci[1:0], downstream_fifo_out_data[i*W +: W]};
                    checks++;
                    if (exp_dn.size() == 0) begin
                        errors++;
                        $display("FAIL dn_beat: got %0h required no beat", got);
                    end else begin
                        ed = exp_dn.pop_front();
                        if (got !== ed) begin
                            errors++;
                            $display("FAIL dn_beat: got %0h required %0h", got, ed);
                        end
                    end
                end
            end
        end
    end

    logic [W-1:0] msg;

    initial begin
        // ---------------- Reset with inputs active: everything gated ----------
        reset = 1'b1;
        for (int i = 0; i < N; i++) child_data[i] = 40'hC0_0000_0010 + 40'(i);
        downstream_fifo_in_valid      = 4'b1111;
        upstream_fifo_out_ready       = 1'b1;
        upstream_fifo_in_data         = {4'hF, 36'h0_0000_0001};
        upstream_fifo_in_valid        = 1'b1;
        downstream_fifo_out_ready     = 4'b1111;
        downstream_has_message_flying = '0;
        downstream_has_odd_clusters   = '0;
        #1;
        chk("rst_up_out_valid", 64'(upstream_fifo_out_valid), 64'd0);
        chk("rst_up_out_data", 64'(upstream_fifo_out_data), 64'd0);
        chk("rst_dn_in_ready", 64'(downstream_fifo_in_ready), 64'd0);
        chk("rst_dn_out_valid", 64'(downstream_fifo_out_valid), 64'd0);
        chk("rst_up_in_ready", 64'(upstream_fifo_in_ready), 64'd0);
        chk("rst_route_error", 64'(route_error), 64'd0);
        tick();
        upstream_fifo_in_valid    = 1'b0;
        downstream_fifo_out_ready = '0;
        tick();

        // ---------------- Round-robin with all children valid ----------------
        for (int k = 0; k < 8; k++) exp_up.push_back(child_data[k % N]);
        reset = 1'b0;
        neg();
        chk("rr_first_grant", 64'(downstream_fifo_in_ready), 64'b0001);
        chk("rr_valid_before", 64'(upstream_fifo_out_valid), 64'd0);
        tick();
        neg();
        chk("rr_valid_after", 64'(upstream_fifo_out_valid), 64'd1);
        chk("rr_second_grant", 64'(downstream_fifo_in_ready), 64'b0010);
        for (int k = 0; k < 7; k++) tick();
        downstream_fifo_in_valid = '0;
        tick();
        tick();
        neg();
        chk("rr_drained", 64'(upstream_fifo_out_valid), 64'd0);

        // ---------------- Single child with output stall ----------------
        tick();
        upstream_fifo_out_ready  = 1'b0;
        child_data[2]            = 40'hAA_0000_0002;
        downstream_fifo_in_valid = 4'b0100;
        exp_up.push_back(40'hAA_0000_0002);
        exp_up.push_back(40'hBB_0000_0002);
        neg();
        chk("stall_grant2", 64'(downstream_fifo_in_ready), 64'b0100);
        tick();
        child_data[2] = 40'hBB_0000_0002;
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("stall_in_ready", 64'(downstream_fifo_in_ready), 64'd0);
            chk("stall_data", 64'(upstream_fifo_out_data), 64'hAA_0000_0002);
            chk("stall_valid", 64'(upstream_fifo_out_valid), 64'd1);
            tick();
        end
        upstream_fifo_out_ready = 1'b1;
        neg();
        chk("stall_release_ready", 64'(downstream_fifo_in_ready), 64'b0100);
        tick();
        downstream_fifo_in_valid = '0;
        tick();
        downstream_fifo_in_valid = 4'b1111;
        neg();
        chk("rr_ptr_after_child2", 64'(downstream_fifo_in_ready), 64'b1000);
        downstream_fifo_in_valid = '0;
        tick();

        // ---------------- Unicast to child 1 with backpressure ----------------
        msg                       = {4'h1, 36'h1_2345_6789};
        upstream_fifo_in_data     = msg;
        upstream_fifo_in_valid    = 1'b1;
        downstream_fifo_out_ready = '0;
        for (int k = 0; k < 2; k++) begin
            neg();
            chk("uc_valid_wait", 64'(downstream_fifo_out_valid), 64'b0010);
            chk("uc_ready_wait", 64'(upstream_fifo_in_ready), 64'd0);
            tick();
        end
        downstream_fifo_out_ready = 4'b0010;
        push_dn(1, msg);
        neg();
        chk("uc_valid_go", 64'(downstream_fifo_out_valid), 64'b0010);
        chk("uc_ready_go", 64'(upstream_fifo_in_ready), 64'd1);
        tick();
        upstream_fifo_in_valid    = 1'b0;
        downstream_fifo_out_ready = '0;

        // ---------------- Broadcast with staggered child readiness ----------------
        msg                       = {4'hF, 36'hB_CAFE_0001};
        upstream_fifo_in_data     = msg;
        upstream_fifo_in_valid    = 1'b1;
        downstream_fifo_out_ready = 4'b1001;
        push_dn(0, msg);
        push_dn(3, msg);
        neg();
        chk("bc_c0_valid", 64'(downstream_fifo_out_valid), 64'b1111);
        chk("bc_c0_ready", 64'(upstream_fifo_in_ready), 64'd0);
        tick();
        neg();
        chk("bc_c1_valid", 64'(downstream_fifo_out_valid), 64'b0110);
        chk("bc_c1_ready", 64'(upstream_fifo_in_ready), 64'd0);
        tick();
        downstream_fifo_out_ready = 4'b1111;
        push_dn(1, msg);
        push_dn(2, msg);
        neg();
        chk("bc_c2_valid", 64'(downstream_fifo_out_valid), 64'b0110);
        chk("bc_c2_ready", 64'(upstream_fifo_in_ready), 64'd1);
        tick();
        // A second broadcast must see a cleared done mask.
        msg                   = {4'hF, 36'hB_CAFE_0002};
        upstream_fifo_in_data = msg;
        for (int i = 0; i < N; i++) push_dn(i, msg);
        neg();
        chk("bc2_valid", 64'(downstream_fifo_out_valid), 64'b1111);
        chk("bc2_ready", 64'(upstream_fifo_in_ready), 64'd1);
        tick();
        upstream_fifo_in_valid    = 1'b0;
        downstream_fifo_out_ready = '0;

        // ---------------- Unicast to nonexistent child ----------------
        upstream_fifo_in_data  = {4'h5, 36'h5_5555_5555};
        upstream_fifo_in_valid = 1'b1;
        downstream_fifo_out_ready = 4'b1111;
        neg();
        chk("bad_ready", 64'(upstream_fifo_in_ready), 64'd1);
        chk("bad_no_valid", 64'(downstream_fifo_out_valid), 64'd0);
        chk("bad_err_before", 64'(route_error), 64'd0);
        tick();
        upstream_fifo_in_valid    = 1'b0;
        downstream_fifo_out_ready = '0;
        neg();
        chk("bad_err_set", 64'(route_error), 64'd1);
        tick();
        tick();
        neg();
        chk("bad_err_sticky", 64'(route_error), 64'd1);
        tick();

        // ---------------- Reset mid-broadcast and mid-stall ----------------
        child_data[0]             = 40'hDD_0000_0000;
        downstream_fifo_in_valid  = 4'b0001;
        upstream_fifo_out_ready   = 1'b0;
        msg                       = {4'hF, 36'hD_0000_0003};
        upstream_fifo_in_data     = msg;
        upstream_fifo_in_valid    = 1'b1;
        downstream_fifo_out_ready = 4'b0101;
        push_dn(0, msg);
        push_dn(2, msg);
        neg();
        chk("mid_bc_valid0", 64'(downstream_fifo_out_valid), 64'b1111);
        tick();
        neg();
        chk("mid_bc_valid1", 64'(downstream_fifo_out_valid), 64'b1010);
        chk("mid_stall_valid", 64'(upstream_fifo_out_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_up_valid", 64'(upstream_fifo_out_valid), 64'd0);
        chk("mid_rst_up_data", 64'(upstream_fifo_out_data), 64'd0);
        chk("mid_rst_dn_valid", 64'(downstream_fifo_out_valid), 64'd0);
        chk("mid_rst_up_in_ready", 64'(upstream_fifo_in_ready), 64'd0);
        chk("mid_rst_dn_in_ready", 64'(downstream_fifo_in_ready), 64'd0);
        chk("mid_rst_route_error", 64'(route_error), 64'd0);
        downstream_fifo_in_valid = '0;
        upstream_fifo_out_ready  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        msg                       = {4'hF, 36'hE_0000_0004};
        upstream_fifo_in_data     = msg;
        downstream_fifo_out_ready = 4'b1111;
        for (int i = 0; i < N; i++) push_dn(i, msg);
        neg();
        chk("post_rst_bc_valid", 64'(downstream_fifo_out_valid), 64'b1111);
        chk("post_rst_bc_ready", 64'(upstream_fifo_in_ready), 64'd1);
        chk("post_rst_up_valid", 64'(upstream_fifo_out_valid), 64'd0);
        tick();
        upstream_fifo_in_valid    = 1'b0;
        downstream_fifo_out_ready = '0;

        // ---------------- Status aggregation ----------------
        neg();
        chk("idle_flying", 64'(upstream_has_message_flying), 64'd0);
        chk("idle_odd", 64'(upstream_has_odd_clusters), 64'd0);
        downstream_has_odd_clusters = 4'b0100;
        #1;
        chk("odd_set", 64'(upstream_has_odd_clusters), 64'd1);
        downstream_has_message_flying = 4'b1000;
        #1;
        chk("flying_child", 64'(upstream_has_message_flying), 64'd1);
        downstream_has_message_flying = '0;
        upstream_fifo_in_valid        = 1'b1;
        upstream_fifo_in_data         = {4'h2, 36'h0};
        #1;
        chk("flying_parent", 64'(upstream_has_message_flying), 64'd1);
        upstream_fifo_in_valid = 1'b0;
        tick();
        tick();

        chk("up_queue_empty", 64'(exp_up.size()), 64'd0);
        chk("dn_queue_empty", 64'(exp_dn.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
